// File: rtl/flash_spi_reader_if.sv
// Host-side read port of the configuration-flash reader, as driven by the STM32 bus bridge.
// enable_in is a level: a rising edge opens a session and low aborts it. continue_read_in is a
// one-cycle pulse that is only honoured while busy_out=0. data_out is valid whenever busy_out=0.
interface flash_spi_reader_if;
   logic       enable_in;
   logic [7:0] cmd_in;
   logic       continue_read_in;
   logic [7:0] data_out;
   logic       busy_out;

   modport master (output enable_in, cmd_in, continue_read_in, input data_out, busy_out);
   modport slave  (input enable_in, cmd_in, continue_read_in, output data_out, busy_out);
endinterface

// File: rtl/flash_spi_reader.sv
// SPI mode-0 master for the configuration flash: sends command plus start address once,
// then returns one sequential byte per continue request until enable drops.
module flash_spi_reader #(
   parameter int          CLK_DIV    = 2,
   parameter int          ADDR_BYTES = 3,
   parameter logic [31:0] START_ADDR = 32'h0
) (
   input  logic              clk_in,
   input  logic              reset_in,
   flash_spi_reader_if.slave host,
   output logic              flash_ncs,
   output logic              flash_sck,
   output logic              flash_mosi,
   input  logic              flash_miso,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETUP     = 3'd1,
      SHIFT_HDR = 3'd2,
      SHIFT_RD  = 3'd3,
      HOLD      = 3'd4
   } state_t;

   localparam int          DW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
   localparam int          HDR_BITS     = 8 * (1 + ADDR_BYTES);
   localparam logic [5:0]  HDR_LAST     = 6'(HDR_BITS);
   // Address bytes left-aligned so the header always shifts out of bit 39.
   localparam logic [31:0] ADDR_ALIGNED = (ADDR_BYTES == 0) ? 32'h0 :
                                          (START_ADDR << (32 - 8 * ADDR_BYTES));

   state_t          state, state_nxt;
   logic [DW-1:0]   div_cnt;
   logic            sck_q;
   logic [5:0]      bit_cnt;
   logic [39:0]     hdr_sr;
   logic [7:0]      rx_sr;
   logic [7:0]      data_q;
   logic            hdr_sent;
   logic            enable_prev;
   logic            armed;
   logic            busy;
   logic            start;
   logic            half_end;
   logic            abort;

   // armed blocks a start when enable is already high as reset releases.
   assign start    = host.enable_in & ~enable_prev & armed;
   assign half_end = (div_cnt == DIV_LAST);
   assign abort    = (state != IDLE) && !host.enable_in;

   always_ff @(posedge clk_in) begin
      if (reset_in) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start) state_nxt = SETUP;
         SETUP:     if (!host.enable_in) state_nxt = IDLE;
                    else if (half_end) state_nxt = hdr_sent ? SHIFT_RD : SHIFT_HDR;
         SHIFT_HDR: if (!host.enable_in) state_nxt = IDLE;
                    else if (half_end && sck_q && bit_cnt == HDR_LAST) state_nxt = SHIFT_RD;
         SHIFT_RD:  if (!host.enable_in) state_nxt = IDLE;
                    else if (half_end && sck_q && bit_cnt == 6'd8) state_nxt = HOLD;
         HOLD:      if (!host.enable_in) state_nxt = IDLE;
                    else if (host.continue_read_in) state_nxt = SETUP;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         div_cnt     <= '0;
         sck_q       <= 1'b0;
         bit_cnt     <= '0;
         hdr_sr      <= '0;
         rx_sr       <= '0;
         data_q      <= '0;
         hdr_sent    <= 1'b0;
         enable_prev <= 1'b0;
         armed       <= 1'b0;
      end else begin
         enable_prev <= host.enable_in;
         if (!host.enable_in) armed <= 1'b1;
         if (abort) begin
            sck_q   <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  sck_q   <= 1'b0;
                  div_cnt <= '0;
                  bit_cnt <= '0;
                  if (start) begin
                     hdr_sr   <= {host.cmd_in, ADDR_ALIGNED};
                     hdr_sent <= 1'b0;
                  end
               end
               SETUP: begin
                  if (half_end) begin
                     div_cnt <= '0;
                     sck_q   <= 1'b1;
                     bit_cnt <= 6'd1;
                     if (hdr_sent) rx_sr <= {rx_sr[6:0], flash_miso};
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               SHIFT_HDR, SHIFT_RD: begin
                  if (half_end) begin
                     div_cnt <= '0;
                     sck_q   <= ~sck_q;
                     if (!sck_q) begin
                        // Rising SCK: the flash samples mosi, we sample miso.
                        bit_cnt <= bit_cnt + 6'd1;
                        if (state == SHIFT_RD) rx_sr <= {rx_sr[6:0], flash_miso};
                     end else if (state == SHIFT_HDR) begin
                        if (bit_cnt == HDR_LAST) begin
                           hdr_sent <= 1'b1;
                           bit_cnt  <= '0;
                        end else begin
                           hdr_sr <= {hdr_sr[38:0], 1'b0};
                        end
                     end else if (bit_cnt == 6'd8) begin
                        data_q  <= rx_sr;
                        bit_cnt <= '0;
                     end
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
               end
               HOLD: begin
                  sck_q   <= 1'b0;
                  div_cnt <= '0;
               end
               default: begin
                  sck_q   <= 1'b0;
                  div_cnt <= '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      flash_ncs  = (state == IDLE);
      busy       = (state != HOLD);
      flash_mosi = 1'b0;
      if (state == SHIFT_HDR || (state == SETUP && !hdr_sent)) flash_mosi = hdr_sr[39];
   end

   assign flash_sck     = sck_q;
   assign host.busy_out = busy;
   assign host.data_out = data_q;
   assign state_dbg     = state;

endmodule

// File: doc/flash_spi_reader.md
Name: flash_spi_reader

Overview:
- SPI master for the FPGA configuration flash (EPCS-class, SPI mode 0).
- Sits directly downstream of the STM32 bus interface's flash-read path:
  - consumes its FLASH_enable, FLASH_data_out (command byte) and FLASH_continue_read;
  - returns FLASH_data_in and FLASH_busy.
- Issues command plus start address, then streams sequential bytes, one per continue request, until enable drops.

Parameters:
- CLK_DIV, 2, clk_in cycles per SCK half-period (≥1).
- ADDR_BYTES, 3, number of address bytes sent after the command (0..4).
- START_ADDR, 32'h0, read start address; low ADDR_BYTES bytes sent MSB first.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset_in  input  1  synchronous reset, active-high.
- enable_in  input  1  level; rising edge starts a read session, low aborts it (FLASH_enable).
- cmd_in  input  8  command byte, latched at session start (FLASH_data_out).
- continue_read_in  input  1  one-cycle pulse: fetch next byte (FLASH_continue_read).
- data_out  output  8  last byte read (FLASH_data_in).
- busy_out  output  1  1 = no valid byte / transfer in progress (FLASH_busy).
- flash_ncs  output  1  chip select, active-low.
- flash_sck  output  1  SPI clock, idles low.
- flash_mosi  output  1  serial data to flash.
- flash_miso  input  1  serial data from flash.

Behaviour:
- Reset values: data_out=0, busy_out=1, flash_ncs=1, flash_sck=0, flash_mosi=0. State is IDLE, enable_prev=0, all counters 0.
- Reset mid-transfer: the same values apply on the next edge, with no SCK glitch (sck forced 0).
- States: IDLE, SETUP, SHIFT_HDR, SHIFT_RD, HOLD.
- IDLE:
  - Start when enable_in=1 and enable_prev=0 (enable_prev is the registered enable_in).
  - On start: latch cmd_in and build a header shift register of cmd_in followed by ADDR_BYTES address bytes.
  - Next cycle: ncs=0, go to SETUP.
  - If enable_in is already high out of reset or after an abort, no start occurs until it goes low and then high again.
- SETUP:
  - Wait CLK_DIV cycles with ncs=0 and sck=0.
  - mosi = header MSB.
  - Go to SHIFT_HDR.
- SHIFT_HDR:
  - SCK toggles every CLK_DIV cycles.
  - mosi changes only while sck is low, on entering a low half.
  - 8*(1+ADDR_BYTES) bits, MSB first; then go to SHIFT_RD without a gap.
- SHIFT_RD:
  - 8 SCK periods, mosi=0.
  - miso is sampled on each SCK rising edge into an 8-bit shift register, MSB first.
  - After the 8th rising edge plus one low half-period: data_out = assembled byte, busy_out=0, sck=0, ncs stays 0, go to HOLD.
  - data_out and the busy_out fall update in the same cycle.
- HOLD:
  - ncs low, sck low; data_out stable.
  - On continue_read_in=1: busy_out=1 next cycle, then wait CLK_DIV cycles and run SHIFT_RD (flash auto-increments the address). No header is resent.
- continue_read_in in any state other than HOLD is ignored and not queued.
- Abort, in any non-IDLE state, when enable_in=0:
  - Next cycle: ncs=1, sck=0, mosi=0, busy_out=1, go to IDLE.
  - data_out keeps its last value.
  - Abort wins over a simultaneous continue_read_in.
- Latency, from the cycle enable_in is first sampled high (cycle 0):
  - ncs falls at cycle 1.
  - First SCK rise at 1+CLK_DIV.
  - Total SCK periods N = 8*(2+ADDR_BYTES).
  - busy_out falls at 1+CLK_DIV+(N-1)*2*CLK_DIV+CLK_DIV.
  - Defaults: 161.
- Latency per continue, from the pulse at cycle c: busy_out=1 at c+1, busy_out=0 at c+1+16*CLK_DIV (defaults: c+33).
- sck duty: exactly CLK_DIV high and CLK_DIV low per period; no short pulses.
- Address wrap at the top of flash is handled by the flash; the block does not count bytes.

Test Plan:
- Reset → ncs=1, sck=0, busy_out=1, data_out=0; hold enable_in=1 through reset release → no SCK activity.
- cmd_in=8'h03, enable 0→1 at cycle 0; flash model serves 8'hA5 at address 0:
  - MOSI captured on SCK rises is 03 00 00 00;
  - 40 SCK periods;
  - busy_out=0 and data_out=8'hA5 at cycle 161.
- In HOLD, pulse continue_read_in at cycle c; model next byte 8'h3C:
  - busy_out=1 at c+1;
  - 8 SCK periods;
  - data_out=8'h3C, busy_out=0 at c+33;
  - ncs stays low throughout.
- Drop enable_in mid SHIFT_HDR (after 10 SCK periods):
  - next cycle ncs=1, sck=0, busy_out=1, state IDLE;
  - re-raise enable_in → full header resent from the first bit.
- continue_read_in pulsed while busy_out=1 → ignored:
  - exactly one byte delivered;
  - HOLD is held until a later pulse.
- CLK_DIV=1, ADDR_BYTES=0, cmd 8'h9F (ID read), model returns 8'h12:
  - busy_out falls at cycle 1+1+15*2+1=33, data_out=8'h12;
  - every sck high/low phase exactly 1 cycle.
